uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
- Command front-end that sits directly upstream of the pulse-sequence generator.
- Consumes bytes from the UART receiver and decodes framed host commands into generator configuration writes (time_address/time_value), run/stop and Ramsey/Rabi control.
- Serves readback requests by walking the generator's tx_address/txbyte_pos mux and streaming the bytes to the UART transmitter.
- Returns ACK/NAK for every accepted frame.

Parameters:
TIMEOUT_CYCLES, 500000, inter-byte timeout in clk cycles (10 ms at 50 MHz); on expiry, a partial frame is discarded.
MAX_TIME_ADDR, 10, highest valid time register address.
RB_LAST_ADDR, 8, last tx_address walked during readback.

Ports:
clk  in  1  system clock (50 MHz)
rst_n  in  1  reset, synchronous, active-low
rx_data  in  8  received byte from UART RX
rx_valid  in  1  one-cycle strobe, rx_data valid
time_address  out  4  generator config address; 0 = no-op
time_value  out  16  generator config value
isrun  out  1  sequence run(1)/stop(0)
isramsey  out  1  Ramsey(1)/Rabi(0) select
tx_address  out  4  generator readback address
txbyte_pos  out  1  readback byte select, 0 = low byte, 1 = high byte
tx_data  in  8  generator readback byte, combinational from tx_address/txbyte_pos
uart_tx_data  out  8  byte to UART TX
uart_tx_start  out  1  one-cycle send strobe
uart_tx_busy  in  1  UART TX busy; goes high the cycle after start and stays high until the byte is done

Behaviour:
- Reset (rst_n=0 at posedge clk): time_address=0, time_value=0, isrun=0, isramsey=0, tx_address=0, txbyte_pos=0, uart_tx_data=0, uart_tx_start=0, state=IDLE, timeout counter=0.
- Reset mid-frame or mid-reply aborts immediately; no strobe is issued.
- Frame format: 0xAA, CMD, payload, CSUM. CSUM = XOR of CMD and all payload bytes.
  - CMD 0x01 write: payload ADDR, VHI, VLO.
  - CMD 0x02 control: payload FLAGS; FLAGS[0]=isrun, FLAGS[1]=isramsey.
  - CMD 0x03 readback: no payload.
  - CMD 0x04 restore defaults: no payload.
- State machine: IDLE -> CMD -> (ADDR -> VHI -> VLO | FLAGS | none) -> CSUM -> EXEC -> REPLY.
  - Readback path: EXEC -> RB_SET -> RB_SAMPLE -> RB_SEND -> RB_WAIT, looping.
- Transitions advance only on rx_valid.
  - IDLE ignores every byte except 0xAA.
  - An unknown CMD returns to IDLE silently, with no reply.
- Timeout counter clears on every rx_valid and counts while the state is neither IDLE nor a reply/readback state. At TIMEOUT_CYCLES-1 the machine returns to IDLE with no reply.
- EXEC, one cycle after the CSUM byte is accepted:
  - Checksum mismatch: no action; reply NAK 0x15.
  - Write: ADDR valid only for 1..MAX_TIME_ADDR, else NAK with no strobe. If valid, time_value={VHI,VLO} and time_address=ADDR[3:0] for exactly one clk, then time_address=0; reply ACK 0x06. time_value holds its last value.
  - Control: isrun/isramsey update in the EXEC cycle and hold until the next control frame or reset; reply ACK.
  - Defaults: time_address=4'hF for exactly one clk (generator restores defaults); reply ACK.
  - Readback: send 0x55 header, then for a = 0..RB_LAST_ADDR send the low byte, then the high byte (19 bytes total). No ACK byte.
- Readback sampling:
  - RB_SET drives tx_address/txbyte_pos.
  - RB_SAMPLE (next cycle) latches tx_data into uart_tx_data.
  - RB_SEND pulses start.
  - After the last byte, tx_address=0 and txbyte_pos=0.
- TX handshake:
  - uart_tx_start pulses for one cycle only when uart_tx_busy=0; uart_tx_data is stable from that cycle until the byte completes.
  - RB_WAIT/ACK-wait skips one guard cycle, then waits for uart_tx_busy=0 before the next byte.
  - If busy is high on entry to a send state, the send waits.
- rx_valid during any reply/readback state: the byte is dropped and no new frame starts. Parsing resumes in IDLE.
- time_address is 0 in every cycle other than the single EXEC strobe cycle. A held nonzero address corrupts generator config.

Test Plan:
- Reset, then bytes AA 01 03 00 C8 CA -> exactly one cycle with time_address=3, time_value=0x00C8; time_address=0 otherwise; UART sends 0x06.
- AA 02 03 01 -> isrun=1, isramsey=1 in EXEC cycle; ACK 0x06. Then AA 02 00 02 -> both 0.
- After reset, AA 03 03 with the generator model attached:
  - UART sends 55, 00 00, 00 00, 64 00, 0A 00, 3C 00, F4 01, 05 00, 9A 01.
  - Final byte pair is 00 00 (addr 8, isrun=0, isramsey=0).
  - Each start is issued only with busy=0.
- AA 01 0B 00 01 0B (addr 11) -> no time_address strobe, NAK 0x15. AA 01 03 00 C8 00 (bad CSUM) -> NAK, no strobe.
- AA 01 03, then idle for TIMEOUT_CYCLES, then AA 04 04 -> first frame discarded with no reply; time_address=0xF for one cycle; ACK.
- Assert rst_n=0 mid-readback (after byte 5) -> all outputs at reset values the next cycle, no further uart_tx_start, isrun=0.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// Bus bundle between the host command parser and its UART / pulse-generator neighbours.
// master = the parser, slave = the environment (UART RX/TX and generator).
interface uart_cmd_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [3:0]  time_address;
  logic [15:0] time_value;
  logic        isrun;
  logic        isramsey;
  logic [3:0]  tx_address;
  logic        txbyte_pos;
  logic [7:0]  tx_data;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_busy;

  modport master (
    input  rx_data, rx_valid, tx_data, uart_tx_busy,
    output time_address, time_value, isrun, isramsey,
           tx_address, txbyte_pos, uart_tx_data, uart_tx_start
  );

  modport slave (
    output rx_data, rx_valid, tx_data, uart_tx_busy,
    input  time_address, time_value, isrun, isramsey,
           tx_address, txbyte_pos, uart_tx_data, uart_tx_start
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Host command front-end: decodes framed UART commands into pulse-generator config
// writes, run/mode control and readback streams, replying ACK/NAK per frame.
//
// state        | meaning
// S_IDLE       | waiting for 0xAA sync byte
// S_CMD        | expecting command byte
// S_ADDR       | write: expecting address
// S_VHI        | write: expecting value high byte
// S_VLO        | write: expecting value low byte
// S_FLAGS      | control: expecting flags byte
// S_CSUM       | expecting checksum; actions launched on accept
// S_EXEC       | one-cycle decision: reply byte or readback start
// S_REPLY      | waiting for TX idle to send ACK/NAK
// S_REPLY_WAIT | guard cycle, then wait for ACK/NAK to finish
// S_RB_SET     | readback mux address driven
// S_RB_SAMPLE  | readback byte latched into TX data
// S_RB_SEND    | waiting for TX idle to send readback byte
// S_RB_WAIT    | guard cycle, then wait for byte done and advance
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned MAX_TIME_ADDR  = 10,
  parameter int unsigned RB_LAST_ADDR   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_cmd_parser_if.master  bus
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_CMD        = 4'd1;
  localparam logic [3:0] S_ADDR       = 4'd2;
  localparam logic [3:0] S_VHI        = 4'd3;
  localparam logic [3:0] S_VLO        = 4'd4;
  localparam logic [3:0] S_FLAGS      = 4'd5;
  localparam logic [3:0] S_CSUM       = 4'd6;
  localparam logic [3:0] S_EXEC       = 4'd7;
  localparam logic [3:0] S_REPLY      = 4'd8;
  localparam logic [3:0] S_REPLY_WAIT = 4'd9;
  localparam logic [3:0] S_RB_SET     = 4'd10;
  localparam logic [3:0] S_RB_SAMPLE  = 4'd11;
  localparam logic [3:0] S_RB_SEND    = 4'd12;
  localparam logic [3:0] S_RB_WAIT    = 4'd13;

  localparam int         CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] MAX_A   = 8'(MAX_TIME_ADDR);
  localparam logic [3:0] RB_LAST = 4'(RB_LAST_ADDR);

  logic [3:0]    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    vhi_q, vhi_d;
  logic [7:0]    vlo_q, vlo_d;
  logic [1:0]    flags_q, flags_d;
  logic [7:0]    csum_q, csum_d;
  logic          nak_q, nak_d;
  logic          hdr_q, hdr_d;
  logic          guard_q, guard_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    time_address_q, time_address_d;
  logic [15:0]   time_value_q, time_value_d;
  logic          isrun_q, isrun_d;
  logic          isramsey_q, isramsey_d;
  logic [3:0]    tx_address_q, tx_address_d;
  logic          txbyte_pos_q, txbyte_pos_d;
  logic [7:0]    uart_tx_data_q, uart_tx_data_d;
  logic          uart_tx_start_q, uart_tx_start_d;

  logic addr_ok, csum_ok, parsing;

  assign addr_ok = (addr_q != 8'd0) && (addr_q <= MAX_A);
  assign csum_ok = (csum_q == bus.rx_data);
  assign parsing = (state_q >= S_CMD) && (state_q <= S_CSUM);

  always_comb begin
    state_d         = state_q;
    cmd_d           = cmd_q;
    addr_d          = addr_q;
    vhi_d           = vhi_q;
    vlo_d           = vlo_q;
    flags_d         = flags_q;
    csum_d          = csum_q;
    nak_d           = nak_q;
    hdr_d           = hdr_q;
    guard_d         = guard_q;
    cnt_d           = '0;
    time_address_d  = 4'h0;
    time_value_d    = time_value_q;
    isrun_d         = isrun_q;
    isramsey_d      = isramsey_q;
    tx_address_d    = tx_address_q;
    txbyte_pos_d    = txbyte_pos_q;
    uart_tx_data_d  = uart_tx_data_q;
    uart_tx_start_d = 1'b0;

    case (state_q)
      S_IDLE: if (bus.rx_valid && bus.rx_data == 8'hAA) state_d = S_CMD;
      S_CMD: if (bus.rx_valid) begin
        cmd_d  = bus.rx_data;
        csum_d = bus.rx_data;
        case (bus.rx_data)
          8'h01:        state_d = S_ADDR;
          8'h02:        state_d = S_FLAGS;
          8'h03, 8'h04: state_d = S_CSUM;
          default:      state_d = S_IDLE;
        endcase
      end
      S_ADDR: if (bus.rx_valid) begin
        addr_d  = bus.rx_data;
        csum_d  = csum_q ^ bus.rx_data;
        state_d = S_VHI;
      end
      S_VHI: if (bus.rx_valid) begin
        vhi_d   = bus.rx_data;
        csum_d  = csum_q ^ bus.rx_data;
        state_d = S_VLO;
      end
      S_VLO: if (bus.rx_valid) begin
        vlo_d   = bus.rx_data;
        csum_d  = csum_q ^ bus.rx_data;
        state_d = S_CSUM;
      end
      S_FLAGS: if (bus.rx_valid) begin
        flags_d = bus.rx_data[1:0];
        csum_d  = csum_q ^ bus.rx_data;
        state_d = S_CSUM;
      end
      // Actions are registered here so the strobe/flags are visible in the EXEC cycle.
      S_CSUM: if (bus.rx_valid) begin
        if (csum_ok) begin
          case (cmd_q)
            8'h01: if (addr_ok) begin
              time_address_d = addr_q[3:0];
              time_value_d   = {vhi_q, vlo_q};
            end
            8'h02: begin
              isrun_d    = flags_q[0];
              isramsey_d = flags_q[1];
            end
            8'h04:   time_address_d = 4'hF;
            default: ;
          endcase
        end
        nak_d   = !csum_ok || (cmd_q == 8'h01 && !addr_ok);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (cmd_q == 8'h03 && !nak_q) begin
          tx_address_d   = 4'h0;
          txbyte_pos_d   = 1'b0;
          hdr_d          = 1'b1;
          uart_tx_data_d = 8'h55;
          state_d        = S_RB_SEND;
        end else begin
          uart_tx_data_d = nak_q ? 8'h15 : 8'h06;
          state_d        = S_REPLY;
        end
      end
      S_REPLY: if (!bus.uart_tx_busy) begin
        uart_tx_start_d = 1'b1;
        guard_d         = 1'b1;
        state_d         = S_REPLY_WAIT;
      end
      S_REPLY_WAIT: begin
        if (guard_q) guard_d = 1'b0;
        else if (!bus.uart_tx_busy) state_d = S_IDLE;
      end
      S_RB_SET: state_d = S_RB_SAMPLE;
      S_RB_SAMPLE: begin
        uart_tx_data_d = bus.tx_data;
        state_d        = S_RB_SEND;
      end
      S_RB_SEND: if (!bus.uart_tx_busy) begin
        uart_tx_start_d = 1'b1;
        guard_d         = 1'b1;
        state_d         = S_RB_WAIT;
      end
      S_RB_WAIT: begin
        if (guard_q) guard_d = 1'b0;
        else if (!bus.uart_tx_busy) begin
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = S_RB_SET;
          end else if (tx_address_q == RB_LAST && txbyte_pos_q) begin
            tx_address_d = 4'h0;
            txbyte_pos_d = 1'b0;
            state_d      = S_IDLE;
          end else if (txbyte_pos_q) begin
            tx_address_d = tx_address_q + 4'd1;
            txbyte_pos_d = 1'b0;
            state_d      = S_RB_SET;
          end else begin
            txbyte_pos_d = 1'b1;
            state_d      = S_RB_SET;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout only while a frame is partially received.
    if (parsing && !bus.rx_valid) begin
      if (cnt_q == TO_LAST) state_d = S_IDLE;
      else cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cmd_q           <= 8'h00;
      addr_q          <= 8'h00;
      vhi_q           <= 8'h00;
      vlo_q           <= 8'h00;
      flags_q         <= 2'b00;
      csum_q          <= 8'h00;
      nak_q           <= 1'b0;
      hdr_q           <= 1'b0;
      guard_q         <= 1'b0;
      cnt_q           <= '0;
      time_address_q  <= 4'h0;
      time_value_q    <= 16'h0000;
      isrun_q         <= 1'b0;
      isramsey_q      <= 1'b0;
      tx_address_q    <= 4'h0;
      txbyte_pos_q    <= 1'b0;
      uart_tx_data_q  <= 8'h00;
      uart_tx_start_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cmd_q           <= cmd_d;
      addr_q          <= addr_d;
      vhi_q           <= vhi_d;
      vlo_q           <= vlo_d;
      flags_q         <= flags_d;
      csum_q          <= csum_d;
      nak_q           <= nak_d;
      hdr_q           <= hdr_d;
      guard_q         <= guard_d;
      cnt_q           <= cnt_d;
      time_address_q  <= time_address_d;
      time_value_q    <= time_value_d;
      isrun_q         <= isrun_d;
      isramsey_q      <= isramsey_d;
      tx_address_q    <= tx_address_d;
      txbyte_pos_q    <= txbyte_pos_d;
      uart_tx_data_q  <= uart_tx_data_d;
      uart_tx_start_q <= uart_tx_start_d;
    end
  end

  assign bus.time_address  = time_address_q;
  assign bus.time_value    = time_value_q;
  assign bus.isrun         = isrun_q;
  assign bus.isramsey      = isramsey_q;
  assign bus.tx_address    = tx_address_q;
  assign bus.txbyte_pos    = txbyte_pos_q;
  assign bus.uart_tx_data  = uart_tx_data_q;
  assign bus.uart_tx_start = uart_tx_start_q;

endmodule
